wqe_fetch_engine: RTL
=====================

Name: wqe_fetch_engine

Overview:
Consumer side of the WQE read scheduling handshake. Takes each scheduled QP index and reads that QP's next send-queue WQE from host memory with a DMA read. Forwards the returned WQE into the WQE cache, then raises fetch_ready so the scheduler can arbitrate again. Owns the per-QP SQ head/tail pointers and produces the active bitmap the scheduler arbitrates over.

Parameters:
MAX_QP, 32, number of queue pairs
QP_PTR_WIDTH, 5, log2(MAX_QP)
WQE_PTR_WIDTH, 8, SQ index width; SQ depth = 2^WQE_PTR_WIDTH entries
ADDR_WIDTH, 64, host address width
WQE_SIZE_LOG2, 6, log2 of WQE bytes (64 B)
DATA_WIDTH, 512, response beat width; one WQE per beat

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_arbit_val  in  1  scheduler grant valid, 1-cycle pulse
i_qp_idx  in  QP_PTR_WIDTH  granted QP
o_wqe_fetch_ready  out  1  engine idle, may be re-arbitrated
o_active  out  MAX_QP  bit q = SQ of QP q non-empty
i_db_val  in  1  doorbell strobe
i_db_qp  in  QP_PTR_WIDTH  doorbell QP
i_db_tail  in  WQE_PTR_WIDTH  new producer index
i_cfg_val  in  1  SQ base write strobe
i_cfg_qp  in  QP_PTR_WIDTH  QP being configured
i_cfg_base  in  ADDR_WIDTH  SQ base address
o_rd_req_val  out  1  DMA read request valid
i_rd_req_rdy  in  1  DMA request accept
o_rd_req_addr  out  ADDR_WIDTH  WQE address
o_rd_req_qp  out  QP_PTR_WIDTH  tag
i_rd_rsp_val  in  1  DMA response valid
i_rd_rsp_data  in  DATA_WIDTH  WQE payload
o_rd_rsp_rdy  out  1  response accept
o_wqe_val  out  1  WQE to cache valid
o_wqe_data  out  DATA_WIDTH  WQE payload
o_wqe_qp  out  QP_PTR_WIDTH  owning QP
i_wqe_cache_rdy  in  1  cache accepts WQE

Behaviour:
- Reset: all heads, tails and bases = 0; FSM = IDLE; o_active = 0; o_wqe_fetch_ready = 1; all other outputs 0.
- Reset mid-operation: any request or response in flight is abandoned. A response arriving after reset is accepted and dropped while in IDLE (o_rd_rsp_rdy = 1 in IDLE).
- o_active[q] = (head[q] != tail[q]), registered. Pointers wrap modulo 2^WQE_PTR_WIDTH.
- FSM state IDLE: o_wqe_fetch_ready = 1.
  - On i_arbit_val with o_active[i_qp_idx] = 1: latch the QP; next state REQ.
  - On i_arbit_val with o_active[i_qp_idx] = 0 (stale or empty grant, including a zero one-hot decoding to 0): ignore; stay in IDLE.
- FSM state REQ: o_rd_req_val = 1; o_rd_req_addr = base[qp] + (head[qp] << WQE_SIZE_LOG2), zero-extended; o_rd_req_qp = latched QP.
  - Address and QP are held stable until i_rd_req_rdy.
  - On val & rdy: next state RSP.
- FSM state RSP: o_rd_rsp_rdy = i_wqe_cache_rdy (pass-through, zero added latency). o_wqe_val = i_rd_rsp_val; o_wqe_data = i_rd_rsp_data; o_wqe_qp = latched QP.
  - On i_rd_rsp_val & i_wqe_cache_rdy: head[qp] increments; next state IDLE.
- o_wqe_fetch_ready is 0 in REQ and RSP. It returns to 1 in the cycle after the response handshake.
- Minimum grant-to-ready latency: 3 cycles (grant -> REQ -> RSP -> IDLE) when rdy and response are immediate.
- i_arbit_val outside IDLE: ignored.
- Doorbell: tail[i_db_qp] <= i_db_tail.
  - Doorbell and head increment on the same QP in the same cycle: both apply; o_active uses both new values.
  - Doorbell making tail == head (full wrap) is a software error; the QP reads as empty.
- Config write: base[i_cfg_qp] <= i_cfg_base. Writing the base of the latched QP during REQ is not allowed.

Optional Feature:
Macro WQE_FETCH_STAT_EN.
- Defined: adds outputs o_stat_fetched (32 bit) and o_stat_dropped (32 bit).
  - o_stat_fetched counts completed WQE deliveries.
  - o_stat_dropped counts ignored IDLE grants to inactive QPs.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- cfg base[3] = 0x1000; doorbell QP3 tail = 2 -> o_active[3] = 1. Grant QP3 -> req addr 0x1000, qp 3. Response delivered; head = 1; ready rises. Second grant -> addr 0x1040. After that response, o_active[3] = 0.
- Grant QP5 with o_active[5] = 0 -> no request; ready stays 1. With WQE_FETCH_STAT_EN defined, o_stat_dropped = 1.
- i_rd_req_rdy held low 10 cycles -> val, addr and qp stable throughout; ready stays 0; a grant pulse during the stall is ignored.
- i_wqe_cache_rdy low while response valid -> o_rd_rsp_rdy = 0 and head unchanged. Raising rdy -> single delivery; head increments once.
- head[7] = 255, tail = 0 (wrapped) -> fetch addr = base + 255*64; head wraps to 0; o_active[7] = 0.
- Assert rst_n low while in RSP -> next cycle: ready = 1, o_rd_req_val = 0, o_active = 0, all pointers 0.

Source files
------------

// File: rtl/wqe_fetch_engine.sv
// WQE fetch engine: schedules one SQ WQE DMA read per grant, owns SQ pointers.
// Optional stat counters under `WQE_FETCH_STAT_EN.
module wqe_fetch_engine #(
  parameter int MAX_QP        = 32,
  parameter int QP_PTR_WIDTH  = 5,
  parameter int WQE_PTR_WIDTH = 8,
  parameter int ADDR_WIDTH    = 64,
  parameter int WQE_SIZE_LOG2 = 6,
  parameter int DATA_WIDTH    = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_arbit_val,
  input  logic [QP_PTR_WIDTH-1:0]  i_qp_idx,
  output logic                     o_wqe_fetch_ready,
  output logic [MAX_QP-1:0]        o_active,
`ifdef WQE_FETCH_STAT_EN
  output logic [31:0]              o_stat_fetched,
  output logic [31:0]              o_stat_dropped,
`endif
  input  logic                     i_db_val,
  input  logic [QP_PTR_WIDTH-1:0]  i_db_qp,
  input  logic [WQE_PTR_WIDTH-1:0] i_db_tail,
  input  logic                     i_cfg_val,
  input  logic [QP_PTR_WIDTH-1:0]  i_cfg_qp,
  input  logic [ADDR_WIDTH-1:0]    i_cfg_base,
  output logic                     o_rd_req_val,
  input  logic                     i_rd_req_rdy,
  output logic [ADDR_WIDTH-1:0]    o_rd_req_addr,
  output logic [QP_PTR_WIDTH-1:0]  o_rd_req_qp,
  input  logic                     i_rd_rsp_val,
  input  logic [DATA_WIDTH-1:0]    i_rd_rsp_data,
  output logic                     o_rd_rsp_rdy,
  output logic                     o_wqe_val,
  output logic [DATA_WIDTH-1:0]    o_wqe_data,
  output logic [QP_PTR_WIDTH-1:0]  o_wqe_qp,
  input  logic                     i_wqe_cache_rdy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [QP_PTR_WIDTH-1:0]  qp_q;
  logic [WQE_PTR_WIDTH-1:0] head     [MAX_QP];
  logic [WQE_PTR_WIDTH-1:0] tail     [MAX_QP];
  logic [WQE_PTR_WIDTH-1:0] head_nxt [MAX_QP];
  logic [WQE_PTR_WIDTH-1:0] tail_nxt [MAX_QP];
  logic [ADDR_WIDTH-1:0]    base     [MAX_QP];
  logic [ADDR_WIDTH-1:0]    head_off;

  logic grant_ok;
  logic grant_drop;
  logic rsp_fire;

  assign grant_ok   = (state == IDLE) & i_arbit_val & o_active[i_qp_idx];
  assign grant_drop = (state == IDLE) & i_arbit_val & ~o_active[i_qp_idx];
  assign rsp_fire   = (state == RSP) & i_rd_rsp_val & i_wqe_cache_rdy;

  assign head_off = ADDR_WIDTH'(head[qp_q]) << WQE_SIZE_LOG2;

  always_comb begin
    state_nxt         = state;
    o_wqe_fetch_ready = 1'b0;
    o_rd_req_val      = 1'b0;
    o_rd_rsp_rdy      = 1'b0;
    o_wqe_val         = 1'b0;
    o_rd_req_addr     = '0;
    o_wqe_data        = '0;
    unique case (state)
      IDLE: begin
        o_wqe_fetch_ready = 1'b1;
        // late responses after a reset are drained here
        o_rd_rsp_rdy      = 1'b1;
        if (grant_ok) state_nxt = REQ;
      end
      REQ: begin
        o_rd_req_val  = 1'b1;
        o_rd_req_addr = base[qp_q] + head_off;
        if (i_rd_req_rdy) state_nxt = RSP;
      end
      RSP: begin
        o_rd_rsp_rdy = i_wqe_cache_rdy;
        o_wqe_val    = i_rd_rsp_val;
        o_wqe_data   = i_rd_rsp_data;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_rd_req_qp = qp_q;
  assign o_wqe_qp    = qp_q;

  always_comb begin
    for (int q = 0; q < MAX_QP; q++) begin
      head_nxt[q] = head[q];
      tail_nxt[q] = tail[q];
      if (rsp_fire && qp_q == QP_PTR_WIDTH'(q))
        head_nxt[q] = head[q] + 1'b1;
      if (i_db_val && i_db_qp == QP_PTR_WIDTH'(q))
        tail_nxt[q] = i_db_tail;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      qp_q  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ok) qp_q <= i_qp_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_active <= '0;
      for (int q = 0; q < MAX_QP; q++) begin
        head[q] <= '0;
        tail[q] <= '0;
        base[q] <= '0;
      end
    end else begin
      for (int q = 0; q < MAX_QP; q++) begin
        head[q]     <= head_nxt[q];
        tail[q]     <= tail_nxt[q];
        o_active[q] <= head_nxt[q] != tail_nxt[q];
      end
      if (i_cfg_val) base[i_cfg_qp] <= i_cfg_base;
    end
  end

`ifdef WQE_FETCH_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_fetched <= '0;
      o_stat_dropped <= '0;
    end else begin
      if (rsp_fire && o_stat_fetched != '1)
        o_stat_fetched <= o_stat_fetched + 1'b1;
      if (grant_drop && o_stat_dropped != '1)
        o_stat_dropped <= o_stat_dropped + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = grant_drop;
`endif

endmodule
